// File: rtl/oam_dma.sv
// NES sprite DMA bus master: a CPU write to the trigger register copies one 256-byte
// CPU page into sprite RAM through the OAM data port, stalling the CPU meanwhile.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_write_en,
   input  logic        cpu_read_en,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_stall,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_write_en,
   output logic        bus_read_en,
   input  logic [7:0]  bus_rdata,
   output logic        dma_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t     r_state;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic [7:0] r_byte_q;
   logic       r_parity;

   logic       w_active;
   logic       w_trigger;

   assign w_active  = (r_state != S_IDLE);
   assign w_trigger = (r_state == S_IDLE) && cpu_write_en && (cpu_addr == DMA_REG_ADDR);

   // Parity is a free-running CPU cycle phase; it decides whether an alignment cycle is needed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_page   <= 8'h00;
         r_idx    <= 8'h00;
         r_byte_q <= 8'h00;
         r_parity <= 1'b0;
      end else begin
         r_parity <= ~r_parity;
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_page  <= cpu_wdata;
                  r_idx   <= 8'h00;
                  r_state <= S_HALT;
               end
            end
            S_HALT: begin
               r_state <= r_parity ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
               r_state <= S_READ;
            end
            S_READ: begin
               r_byte_q <= bus_rdata;
               r_state  <= S_WRITE;
            end
            S_WRITE: begin
               r_idx   <= r_idx + 8'd1;
               r_state <= (r_idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // The bus mux must stay combinational so idle CPU accesses reach the decoder in the same cycle.
   always_comb begin
      bus_addr     = cpu_addr;
      bus_wdata    = cpu_wdata;
      bus_write_en = cpu_write_en;
      bus_read_en  = cpu_read_en;
      case (r_state)
         S_IDLE: begin
            bus_addr     = cpu_addr;
            bus_wdata    = cpu_wdata;
            bus_write_en = cpu_write_en;
            bus_read_en  = cpu_read_en;
         end
         S_HALT, S_ALIGN: begin
            bus_addr     = cpu_addr;
            bus_wdata    = r_byte_q;
            bus_write_en = 1'b0;
            bus_read_en  = 1'b0;
         end
         S_READ: begin
            bus_addr     = {r_page, r_idx};
            bus_wdata    = r_byte_q;
            bus_write_en = 1'b0;
            bus_read_en  = 1'b1;
         end
         S_WRITE: begin
            bus_addr     = OAM_DATA_ADDR;
            bus_wdata    = r_byte_q;
            bus_write_en = 1'b1;
            bus_read_en  = 1'b0;
         end
         default: begin
            bus_write_en = 1'b0;
            bus_read_en  = 1'b0;
         end
      endcase
   end

   assign cpu_rdata = bus_rdata;
   assign cpu_stall = w_active;
   assign dma_busy  = w_active;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: decoder/RAM/OAM model, idle pass-through vector table,
// and directed DMA sequences (even/odd start, page wrap, mid-transfer reset, ignored CPU strobes).
module tb_oam_dma;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_write_en;
   logic        cpu_read_en;
   logic [7:0]  cpu_rdata;
   logic        cpu_stall;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_write_en;
   logic        bus_read_en;
   logic [7:0]  bus_rdata;
   logic        dma_busy;

   oam_dma dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_write_en (cpu_write_en),
      .cpu_read_en  (cpu_read_en),
      .cpu_rdata    (cpu_rdata),
      .cpu_stall    (cpu_stall),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_write_en (bus_write_en),
      .bus_read_en  (bus_read_en),
      .bus_rdata    (bus_rdata),
      .dma_busy     (dma_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Decoder model: flat RAM, OAMADDR at $2003, OAMDATA at $2004 with auto-increment.
   logic [7:0] ram [0:65535];
   logic [7:0] oam [0:255];
   logic [7:0] oamaddr;
   logic       fill_req;
   logic [7:0] fill_pg;
   logic [7:0] fill_x;
   logic       oam_clr_req;

   assign bus_rdata = ram[bus_addr];

   always @(posedge clk) begin
      if (fill_req)
         for (int i = 0; i < 256; i++) ram[{fill_pg, i[7:0]}] <= i[7:0] ^ fill_x;
      if (oam_clr_req)
         for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
      if (bus_write_en) begin
         if (bus_addr == 16'h2004) begin
            oam[oamaddr] <= bus_wdata;
            oamaddr      <= oamaddr + 8'd1;
         end else if (bus_addr == 16'h2003) begin
            oamaddr <= bus_wdata;
         end else begin
            ram[bus_addr] <= bus_wdata;
         end
      end
   end

   // Bench copy of the DUT's cycle parity: counts edges since reset release.
   int edges;
   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   // Bus monitor, sampled on the falling edge.
   logic [15:0] rq[$];
   logic [7:0]  wq[$];
   int mcyc = 0;
   int t0_cyc = -100;
   int stall_tot = 0;
   int dummy_tot = 0;
   int busy_bad = 0;
   int wr_all = 0;
   int rd_all = 0;
   logic [1:0] strb_at [0:3];
   int off;

   always @(negedge clk) begin
      off = mcyc - t0_cyc;
      if (off >= 0 && off < 4) strb_at[off] = {bus_write_en, bus_read_en};
      if (cpu_stall) stall_tot++;
      if (cpu_stall && !bus_read_en && !bus_write_en) dummy_tot++;
      if (dma_busy !== cpu_stall) busy_bad++;
      if (bus_write_en) wr_all++;
      if (bus_read_en) rd_all++;
      if (bus_write_en && bus_addr == 16'h2004) wq.push_back(bus_wdata);
      if (bus_read_en) rq.push_back(bus_addr);
      mcyc++;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle();
      cpu_addr     = 16'h0000;
      cpu_wdata    = 8'h00;
      cpu_write_en = 1'b0;
      cpu_read_en  = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_wdata = d; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
      step();
      cpu_idle();
   endtask

   task automatic fill_page(input logic [7:0] pg, input logic [7:0] x);
      fill_pg = pg; fill_x = x; fill_req = 1'b1;
      step();
      fill_req = 1'b0;
   endtask

   task automatic clear_oam();
      oam_clr_req = 1'b1;
      step();
      oam_clr_req = 1'b0;
   endtask

   // Issues the trigger write so that parity in the HALT cycle equals 'odd'.
   task automatic start_dma(input logic [7:0] pg, input bit odd);
      int guard;
      guard = 0;
      while ((((edges + 1) % 2) != int'(odd)) && guard < 4) begin
         step();
         guard++;
      end
      t0_cyc = mcyc;
      cpu_addr = 16'h4014; cpu_wdata = pg; cpu_write_en = 1'b1;
      step();
      cpu_idle();
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (dma_busy && n < 700) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_done_in_time"}, 64'(n < 700), 64'd1);
      step();
   endtask

   // Runs a complete DMA and checks strobe counts, stall length, read order and sprite data.
   task automatic run_dma(input string nm, input logic [7:0] pg, input logic [7:0] x, input bit odd);
      int wb, rb, sb, db, wa, ra, bad_w, bad_r, bad_o;
      cpu_write(16'h2003, 8'h00);
      wb = wq.size(); rb = rq.size(); sb = stall_tot; db = dummy_tot; wa = wr_all; ra = rd_all;
      start_dma(pg, odd);
      wait_done(nm);
      check({nm, "_stall_cycles"}, 64'(stall_tot - sb), odd ? 64'd514 : 64'd513);
      check({nm, "_dummy_cycles"}, 64'(dummy_tot - db), odd ? 64'd2 : 64'd1);
      check({nm, "_oam_writes"}, 64'(wq.size() - wb), 64'd256);
      check({nm, "_all_writes"}, 64'(wr_all - wa), 64'd257);
      check({nm, "_all_reads"}, 64'(rd_all - ra), 64'd256);
      check({nm, "_t2_strobes"}, 64'(strb_at[2]), odd ? 64'd0 : 64'd1);
      bad_w = 0; bad_r = 0; bad_o = 0;
      for (int k = 0; k < 256; k++) begin
         if (wb + k >= wq.size() || wq[wb + k] !== (k[7:0] ^ x)) bad_w++;
         if (rb + k >= rq.size() || rq[rb + k] !== {pg, k[7:0]}) bad_r++;
         if (oam[k] !== (k[7:0] ^ x)) bad_o++;
      end
      check({nm, "_write_data_errs"}, 64'(bad_w), 64'd0);
      check({nm, "_read_addr_errs"}, 64'(bad_r), 64'd0);
      check({nm, "_sprite_ram_errs"}, 64'(bad_o), 64'd0);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        we;
      logic        re;
      logic [7:0]  exp_rd;
   } pt_vec_t;

   pt_vec_t vecs [0:3];

   initial begin
      int wn, bad_lo, bad_hi, pre, ra, rbase, bad_pg;
      bit found;
      fill_req = 1'b0; fill_pg = 8'h00; fill_x = 8'h00; oam_clr_req = 1'b0;

      // Pass-through vectors; page $20 is filled with addr^$9E, so $2002 reads $9C.
      vecs[0] = '{16'h2000, 8'h80, 1'b1, 1'b0, 8'h9E};
      vecs[1] = '{16'h2002, 8'h00, 1'b0, 1'b1, 8'h9C};
      vecs[2] = '{16'h2003, 8'h00, 1'b1, 1'b0, 8'h9D};
      vecs[3] = '{16'h2005, 8'h11, 1'b0, 1'b0, 8'h9B};

      rst = 1'b0;
      cpu_addr = 16'h1234; cpu_wdata = 8'h56; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
      #2;
      check("reset_passthru", {bus_addr, bus_wdata, bus_write_en, bus_read_en, cpu_stall, dma_busy},
            {16'h1234, 8'h56, 1'b1, 1'b0, 1'b0, 1'b0});
      cpu_idle();
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      step();

      fill_page(8'h20, 8'h9E);
      fill_page(8'h02, 8'h5A);
      fill_page(8'h03, 8'hC3);
      fill_page(8'hFF, 8'hA5);

      for (int i = 0; i < 4; i++) begin
         cpu_addr = vecs[i].a; cpu_wdata = vecs[i].d;
         cpu_write_en = vecs[i].we; cpu_read_en = vecs[i].re;
         #1;
         check($sformatf("idle_vec%0d", i),
               {bus_addr, bus_wdata, bus_write_en, bus_read_en, cpu_rdata, cpu_stall, dma_busy},
               {vecs[i].a, vecs[i].d, vecs[i].we, vecs[i].re, vecs[i].exp_rd, 1'b0, 1'b0});
         step();
         cpu_idle();
      end

      clear_oam();
      run_dma("even", 8'h02, 8'h5A, 1'b0);
      clear_oam();
      run_dma("odd", 8'h02, 8'h5A, 1'b1);
      check("odd_t3_strobes", 64'(strb_at[3]), 64'd1);

      clear_oam();
      run_dma("wrap", 8'hFF, 8'hA5, 1'b1);
      check("wrap_last_read_addr", 64'(rq[rq.size() - 1]), 64'hFFFF);
      check("busy_matches_stall", 64'(busy_bad), 64'd0);

      // Strobes during the transfer: a second trigger and a read must be ignored.
      clear_oam();
      cpu_write(16'h2003, 8'h00);
      pre = wq.size(); ra = rd_all; rbase = rq.size();
      start_dma(8'h02, 1'b0);
      repeat (40) step();
      cpu_addr = 16'h4014; cpu_wdata = 8'h03; cpu_write_en = 1'b1;
      step();
      cpu_idle();
      cpu_addr = 16'h0000; cpu_read_en = 1'b1;
      step();
      cpu_idle();
      wait_done("ignore");
      check("ignore_oam_writes", 64'(wq.size() - pre), 64'd256);
      check("ignore_reads", 64'(rd_all - ra), 64'd256);
      bad_pg = 0; bad_lo = 0;
      for (int k = 0; k < 256; k++) begin
         if (rq[rbase + k][15:8] !== 8'h02) bad_pg++;
         if (oam[k] !== (k[7:0] ^ 8'h5A)) bad_lo++;
      end
      check("ignore_read_page_errs", 64'(bad_pg), 64'd0);
      check("ignore_sprite_errs", 64'(bad_lo), 64'd0);

      // Reset during the WRITE of byte 100 (data 100^$5A = $3E).
      clear_oam();
      cpu_write(16'h2003, 8'h00);
      start_dma(8'h02, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 700 && !found; n++) begin
         @(negedge clk);
         if (bus_write_en && bus_addr == 16'h2004 && bus_wdata == 8'h3E) found = 1'b1;
      end
      check("rst_mid_reached_byte100", 64'(found), 64'd1);
      #1 rst = 1'b0;
      #1;
      check("rst_mid_passthru", {cpu_stall, dma_busy, bus_write_en, bus_read_en}, 4'b0000);
      wn = wq.size();
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      repeat (20) step();
      check("rst_mid_no_more_writes", 64'(wq.size() - wn), 64'd0);
      bad_lo = 0; bad_hi = 0;
      for (int k = 0; k < 100; k++)  if (oam[k] !== (k[7:0] ^ 8'h5A)) bad_lo++;
      for (int k = 101; k < 256; k++) if (oam[k] !== 8'hEE) bad_hi++;
      check("rst_mid_bytes_0_99", 64'(bad_lo), 64'd0);
      check("rst_mid_bytes_101_255", 64'(bad_hi), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

CPU-side bus master that executes NES sprite DMA: a CPU write to $4014 copies 256 bytes from CPU page `{data,8'h00}` into sprite RAM through the OAM data port at $2004. It sits directly upstream of the memory decoder. The CPU bus passes through it untouched when idle. During a transfer it stalls the CPU and takes over the decoder's `cpu_addr` / `cpu_data_in` / `cpu_write_en` / `cpu_read_en` inputs.

## Interface
- `DMA_REG_ADDR`, default 16'h4014: CPU address that triggers DMA.
- `OAM_DATA_ADDR`, default 16'h2004: destination address written for every byte.
- `clk` input 1: system clock, one CPU cycle per clock. Reset is `rst`, asynchronous, active-low; clock is `clk`.
- `rst` input 1: asynchronous active-low reset.
- `cpu_addr` input 16: CPU address.
- `cpu_wdata` input 8: CPU write data.
- `cpu_write_en` input 1: CPU write strobe.
- `cpu_read_en` input 1: CPU read strobe.
- `cpu_rdata` output 8: read data to CPU, always equal to `bus_rdata`.
- `cpu_stall` output 1: CPU RDY-low. While high, the CPU holds its state and its strobes are ignored.
- `bus_addr` output 16: to decoder `cpu_addr`.
- `bus_wdata` output 8: to decoder `cpu_data_in`.
- `bus_write_en` output 1: to decoder `cpu_write_en`.
- `bus_read_en` output 1: to decoder `cpu_read_en`.
- `bus_rdata` input 8: from decoder `cpu_data_out`. It is combinational: valid in the same cycle as the address and sampled at the closing edge.
- `dma_busy` output 1: high from the HALT cycle through the last WRITE cycle.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - `bus_*` equal `cpu_*` combinationally.
  - `cpu_stall`=0.
  - A cycle with `cpu_write_en`=1 and `cpu_addr`==DMA_REG_ADDR passes through to the decoder, latches `page`<=`cpu_wdata`, clears `idx`<=0 and moves to HALT.
- HALT: one dummy cycle. No bus strobes; `bus_addr`=`cpu_addr`.
  - Next state is ALIGN if `parity`==1 during this cycle, otherwise READ.
- ALIGN: one dummy cycle with no strobes, then READ.
- READ:
  - `bus_addr`={page,idx}, `bus_read_en`=1.
  - `bus_rdata` is latched into `byte_q` at the closing edge. Next state is WRITE.
- WRITE:
  - `bus_addr`=OAM_DATA_ADDR, `bus_wdata`=`byte_q`, `bus_write_en`=1.
  - Then `idx`<=`idx`+1 (8-bit).
  - Next state is IDLE if `idx`==8'hFF, otherwise READ.
- `cpu_stall` and `dma_busy` = (state != IDLE). These are decoded from state, not registered separately.
- `parity`:
  - Free-running 1-bit register that toggles every clk.
  - It runs independently of the DMA.
- Arithmetic rules:
  - `idx` wraps at 8 bits and never carries into `page`. Page $FF reads $FF00–$FFFF only.
  - Destination slot order comes from the decoder's OAM address auto-increment. The DMA starts at whatever OAMADDR holds; the block itself never writes $2003.
- Inputs ignored while not IDLE: CPU strobes, `cpu_wdata`, and any $4014 write. A $4014 write is not restartable mid-transfer.
- Reset at any point forces IDLE, `idx`=0, `page`=0, `byte_q`=0, `parity`=0. Outputs return to pass-through immediately (async). A partial transfer is abandoned with no further writes.

## Timing
- Reset values:
  - `cpu_stall`=0, `dma_busy`=0.
  - `bus_*` = pass-through of `cpu_*`.
  - `cpu_rdata`=`bus_rdata`.
- T0: the $4014 write cycle (not stalled).
- T1: HALT.
- Even case (`parity`=0 at T1): READ/WRITE pairs occupy T2..T513. `cpu_stall` is high for exactly 513 cycles, T1–T513.
- Odd case: ALIGN at T2 and pairs at T3..T514. `cpu_stall` is high for 514 cycles.
- Byte k:
  - Read at T(2+a+2k), where a = 1 if ALIGN was inserted, else 0.
  - Written at T(3+a+2k).
- The first cycle after the last WRITE is IDLE with pass-through and `cpu_stall`=0.
- Back-to-back $4014 writes: a new DMA may start on the first IDLE cycle.
- Exactly 256 `bus_write_en` pulses and 256 `bus_read_en` pulses per complete DMA. No strobe in HALT or ALIGN.

## Test plan
- **Even start.** Preload RAM $0200+i = i^8'h5A, parity even at T1, write $4014 ← 8'h02.
  - `cpu_stall` high 513 cycles.
  - 256 writes to $2004 carrying 8'h5A, 8'h5B, … in order.
  - Sprite RAM byte i = i^8'h5A.
- **Odd start.** Same as even start but with parity odd at T1.
  - Stall is 514 cycles.
  - T2 has no strobes.
  - Data is identical.
- **Idle pass-through.**
  - CPU write $2000 ← 8'h80: reaches the decoder the same cycle, `cpu_stall`=0.
  - CPU read of $2002 returns `bus_rdata`.
- **Page wrap.** Page 8'hFF: last read address is $FFFF, with no access to $0000. `dma_busy` drops after byte 255.
- **Reset mid-transfer.** Assert `rst` during the WRITE of byte 100.
  - `cpu_stall`=0 immediately.
  - No further $2004 writes.
  - Sprite RAM bytes 0–99 are written; bytes 101–255 are unchanged.
- **CPU strobes during DMA.** Drive CPU write $4014 ← 8'h03 and read $0000 mid-DMA.
  - Both are ignored.
  - Transfer completes from page $02 with a total of 256 writes.
